// File: rtl/washer_collect_ctrl.sv
// washer_collect_ctrl: sequences rover drive motors and the pickup electromagnet
// around washer detections. Drives while searching, stops on each new detection,
// settles, energises the magnet for a fixed hold, then ignores the sensor for a
// lockout window while driving off the washer. Halts when the hopper is full.
module washer_collect_ctrl #(
    parameter int unsigned SETTLE_CYCLES  = 1_000_000,
    parameter int unsigned HOLD_CYCLES    = 5_000_000,
    parameter int unsigned LOCKOUT_CYCLES = 20_000_000,
    parameter int unsigned MAX_WASHERS    = 8,
    parameter int unsigned CNT_W          = 4
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             enable,
    input  logic             washer_found,
    input  logic             clear_count,
    output logic             motor_en,
    output logic             magnet_on,
    output logic [CNT_W-1:0] washer_count,
    output logic             busy,
    output logic             full
);

    // Phase timer is sized for the longest of the three timed phases.
    localparam int unsigned MAX_SH  = (SETTLE_CYCLES > HOLD_CYCLES) ? SETTLE_CYCLES : HOLD_CYCLES;
    localparam int unsigned MAX_CYC = (MAX_SH > LOCKOUT_CYCLES) ? MAX_SH : LOCKOUT_CYCLES;
    localparam int unsigned TMR_W   = ($clog2(MAX_CYC) < 1) ? 1 : $clog2(MAX_CYC);

    // Timer reload values: a phase of N cycles counts N-1 down to 0.
    localparam logic [TMR_W-1:0] SETTLE_LOAD = TMR_W'(SETTLE_CYCLES - 1);
    localparam logic [TMR_W-1:0] HOLD_LOAD   = TMR_W'(HOLD_CYCLES - 1);
    localparam logic [TMR_W-1:0] LOCK_LOAD   = TMR_W'(LOCKOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] MAX_CNT     = CNT_W'(MAX_WASHERS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRIVE,
        S_STOP,
        S_PICKUP,
        S_LOCKOUT,
        S_FULL
    } state_e;

    state_e             state_q, state_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               prev_q;
    logic               det;
    logic [CNT_W-1:0]   count_inc;

    // Rising edge of the detector level; a held level never retriggers.
    assign det       = washer_found & ~prev_q;
    assign count_inc = count_q + 1'b1;

    // State, timer, count and edge-detect registers.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
            timer_q <= '0;
            count_q <= '0;
            prev_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            count_q <= count_d;
            prev_q  <= washer_found;
        end
    end

    // Next-state, timer and count update.
    // NOTE: every signal written here gets a hold-value default first, so no
    // path through the case leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        count_d = count_q;
        case (state_q)
            S_IDLE: begin
                if (clear_count) begin
                    count_d = '0;
                end else if (enable) begin
                    state_d = S_DRIVE;
                end
            end
            S_DRIVE: begin
                if (!enable) begin
                    state_d = S_IDLE;
                end else if (det) begin
                    state_d = S_STOP;
                    timer_d = SETTLE_LOAD;
                end
            end
            S_STOP: begin
                // enable is deliberately ignored until the pickup completes
                if (timer_q == '0) begin
                    state_d = S_PICKUP;
                    timer_d = HOLD_LOAD;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            S_PICKUP: begin
                if (timer_q == '0) begin
                    count_d = count_inc;
                    if (count_inc == MAX_CNT) begin
                        state_d = S_FULL;
                    end else if (!enable) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_LOCKOUT;
                        timer_d = LOCK_LOAD;
                    end
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            S_LOCKOUT: begin
                // det is ignored here; prev_q still tracks the sensor so a
                // level still high at exit does not fire on DRIVE entry
                if (!enable) begin
                    state_d = S_IDLE;
                end else if (timer_q == '0) begin
                    state_d = S_DRIVE;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            S_FULL: begin
                if (clear_count) begin
                    count_d = '0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs decoded purely from registered state and count.
    always_comb begin
        motor_en     = (state_q == S_DRIVE) || (state_q == S_LOCKOUT);
        busy         = (state_q == S_STOP) || (state_q == S_PICKUP);
        full         = (state_q == S_FULL);
        // the magnet keeps holding collected washers until the count is cleared
        magnet_on    = (state_q == S_PICKUP) || (count_q != '0);
        washer_count = count_q;
    end

endmodule

// File: tb/tb_washer_collect_ctrl.sv
// tb_washer_collect_ctrl: directed scenarios for washer_collect_ctrl with
// SETTLE=4, HOLD=8, LOCKOUT=6, MAX=3. Inputs change on the falling edge and
// outputs are sampled there, half a cycle after the active edge.
module tb_washer_collect_ctrl;

    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic          washer_found = 1'b0;
    logic          clear_count = 1'b0;
    logic          motor_en;
    logic          magnet_on;
    logic          busy;
    logic          full;
    logic [CW-1:0] washer_count;

    int total = 0;
    int bad   = 0;

    washer_collect_ctrl #(
        .SETTLE_CYCLES (4),
        .HOLD_CYCLES   (8),
        .LOCKOUT_CYCLES(6),
        .MAX_WASHERS   (3),
        .CNT_W         (CW)
    ) dut (
        .CLK          (clk),
        .RST_N        (rst_n),
        .enable       (enable),
        .washer_found (washer_found),
        .clear_count  (clear_count),
        .motor_en     (motor_en),
        .magnet_on    (magnet_on),
        .washer_count (washer_count),
        .busy         (busy),
        .full         (full)
    );

    always #5 clk = ~clk;

    // Advance to the next falling edge (one full clock cycle).
    task automatic step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        total++;
        if ({motor_en, magnet_on, busy, full} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_outputs: got motor/mag/busy/full=%b want 0000", {motor_en, magnet_on, busy, full});
        end
        total++;
        if (washer_count !== 4'd0) begin
            bad++;
            $display("FAIL reset_count: got %0d want 0", washer_count);
        end
        @(negedge clk);
        rst_n  = 1'b1;
        enable = 1'b1;
        step();
        total++;
        if (motor_en !== 1'b1) begin
            bad++;
            $display("FAIL reset_release_drive: got motor_en=%b want 1", motor_en);
        end
    endtask

    task automatic test_single();
        int low_cnt = 0;
        int busy_cnt = 0;
        int first_low = -1;
        int first_mag = -1;
        bit mag_drop = 1'b0;
        logic [CW-1:0] cnt12 = '0;
        logic [CW-1:0] cnt13 = '0;
        repeat (18) step();
        washer_found = 1'b1;
        for (int s = 1; s <= 60; s++) begin
            step();
            if (!motor_en) begin
                low_cnt++;
                if (first_low < 0) first_low = s;
            end
            if (busy) busy_cnt++;
            if (magnet_on && first_mag < 0) first_mag = s;
            if (!magnet_on && first_mag >= 0) mag_drop = 1'b1;
            if (s == 12) cnt12 = washer_count;
            if (s == 13) cnt13 = washer_count;
        end
        washer_found = 1'b0;
        total++;
        if (low_cnt != 12) begin
            bad++;
            $display("FAIL single_motor_off_cycles: got %0d want 12", low_cnt);
        end
        total++;
        if (first_low != 1) begin
            bad++;
            $display("FAIL single_detect_latency: got cycle %0d want 1", first_low);
        end
        total++;
        if (busy_cnt != 12) begin
            bad++;
            $display("FAIL single_busy_cycles: got %0d want 12", busy_cnt);
        end
        total++;
        if (first_mag != 5 || mag_drop) begin
            bad++;
            $display("FAIL single_magnet: got first=%0d dropped=%0b want first=5 dropped=0", first_mag, mag_drop);
        end
        total++;
        if (cnt12 !== 4'd0 || cnt13 !== 4'd1) begin
            bad++;
            $display("FAIL single_count_edge: got c12=%0d c13=%0d want 0,1", cnt12, cnt13);
        end
        total++;
        if (washer_count !== 4'd1) begin
            bad++;
            $display("FAIL single_no_retrigger: got count=%0d want 1", washer_count);
        end
        step();
    endtask

    task automatic test_lockout();
        int hi_early = 0;
        int low_mid = 0;
        logic [CW-1:0] cnt18 = '0;
        logic [CW-1:0] cnt21 = '0;
        logic busy22 = 1'b0;
        logic full33 = 1'b1;
        washer_found = 1'b1;
        for (int s = 1; s <= 34; s++) begin
            step();
            if (s <= 12 && motor_en) hi_early++;
            if (s >= 13 && s <= 21 && !motor_en) low_mid++;
            if (s == 18) cnt18 = washer_count;
            if (s == 21) cnt21 = washer_count;
            if (s == 22) busy22 = busy;
            if (s == 33) full33 = full;
            if (s == 1 || s == 15 || s == 22) washer_found = 1'b0;
            if (s == 14 || s == 21) washer_found = 1'b1;
        end
        total++;
        if (hi_early != 0) begin
            bad++;
            $display("FAIL lockout_second_stop: got %0d motor-on cycles want 0", hi_early);
        end
        total++;
        if (low_mid != 0) begin
            bad++;
            $display("FAIL lockout_pulse_ignored: got %0d motor-off cycles want 0", low_mid);
        end
        total++;
        if (cnt18 !== 4'd2 || cnt21 !== 4'd2) begin
            bad++;
            $display("FAIL lockout_count_hold: got c18=%0d c21=%0d want 2,2", cnt18, cnt21);
        end
        total++;
        if (busy22 !== 1'b1) begin
            bad++;
            $display("FAIL lockout_drive_detect: got busy=%b want 1", busy22);
        end
        total++;
        if (full33 !== 1'b0 || full !== 1'b1 || washer_count !== 4'd3 || motor_en !== 1'b0) begin
            bad++;
            $display("FAIL full_entry: got full33=%b full=%b count=%0d motor=%b want 0,1,3,0", full33, full, washer_count, motor_en);
        end
    endtask

    task automatic test_full_clear();
        for (int s = 1; s <= 10; s++) begin
            washer_found = (s % 2 == 1);
            step();
        end
        washer_found = 1'b0;
        step();
        total++;
        if (full !== 1'b1 || washer_count !== 4'd3 || motor_en !== 1'b0 || magnet_on !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL full_hold: got full=%b count=%0d motor=%b mag=%b busy=%b want 1,3,0,1,0", full, washer_count, motor_en, magnet_on, busy);
        end
        clear_count = 1'b1;
        step();
        clear_count = 1'b0;
        total++;
        if (full !== 1'b0 || washer_count !== 4'd0 || magnet_on !== 1'b0 || motor_en !== 1'b0) begin
            bad++;
            $display("FAIL full_clear_idle: got full=%b count=%0d mag=%b motor=%b want 0,0,0,0", full, washer_count, magnet_on, motor_en);
        end
        step();
        total++;
        if (motor_en !== 1'b1) begin
            bad++;
            $display("FAIL full_clear_drive: got motor_en=%b want 1", motor_en);
        end
    endtask

    task automatic test_enable_mid_pickup();
        int motor_hi = 0;
        logic busy1 = 1'b0;
        logic [CW-1:0] cnt12 = '1;
        logic mag12 = 1'b0;
        step();
        washer_found = 1'b1;
        for (int s = 1; s <= 20; s++) begin
            step();
            if (s == 1) begin
                washer_found = 1'b0;
                enable = 1'b0;
                busy1 = busy;
            end
            if (motor_en) motor_hi++;
            if (s == 12) begin
                cnt12 = washer_count;
                mag12 = magnet_on;
            end
        end
        total++;
        if (busy1 !== 1'b1) begin
            bad++;
            $display("FAIL mid_stop_entry: got busy=%b want 1", busy1);
        end
        total++;
        if (motor_hi != 0) begin
            bad++;
            $display("FAIL mid_motor_off: got %0d motor-on cycles want 0", motor_hi);
        end
        total++;
        if (cnt12 !== 4'd0 || mag12 !== 1'b1) begin
            bad++;
            $display("FAIL mid_last_pickup: got count=%0d mag=%b want 0,1", cnt12, mag12);
        end
        total++;
        if (washer_count !== 4'd1 || busy !== 1'b0 || full !== 1'b0 || magnet_on !== 1'b1) begin
            bad++;
            $display("FAIL mid_idle_after: got count=%0d busy=%b full=%b mag=%b want 1,0,0,1", washer_count, busy, full, magnet_on);
        end
    endtask

    task automatic test_ignored_clear();
        logic [CW-1:0] cnt13 = '0;
        enable = 1'b1;
        step();
        clear_count = 1'b1;
        step();
        clear_count = 1'b0;
        total++;
        if (washer_count !== 4'd1 || motor_en !== 1'b1) begin
            bad++;
            $display("FAIL ign_clear: got count=%0d motor=%b want 1,1", washer_count, motor_en);
        end
        washer_found = 1'b1;
        for (int s = 1; s <= 19; s++) begin
            step();
            if (s == 1) begin
                washer_found = 1'b0;
                total++;
                if (busy !== 1'b1) begin
                    bad++;
                    $display("FAIL ign_clear_still_drive: got busy=%b want 1", busy);
                end
            end
            if (s == 13) cnt13 = washer_count;
        end
        total++;
        if (cnt13 !== 4'd2 || motor_en !== 1'b1) begin
            bad++;
            $display("FAIL ign_clear_second: got count=%0d motor=%b want 2,1", cnt13, motor_en);
        end
    endtask

    task automatic test_reset_mid();
        washer_found = 1'b1;
        step();
        washer_found = 1'b0;
        repeat (6) step();
        total++;
        if (busy !== 1'b1 || magnet_on !== 1'b1 || washer_count !== 4'd2) begin
            bad++;
            $display("FAIL rmid_in_pickup: got busy=%b mag=%b count=%0d want 1,1,2", busy, magnet_on, washer_count);
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({motor_en, magnet_on, busy, full} !== 4'b0000 || washer_count !== 4'd0) begin
            bad++;
            $display("FAIL rmid_async: got motor/mag/busy/full=%b count=%0d want 0000,0", {motor_en, magnet_on, busy, full}, washer_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        total++;
        if (motor_en !== 1'b1 || washer_count !== 4'd0 || magnet_on !== 1'b0) begin
            bad++;
            $display("FAIL rmid_release: got motor=%b count=%0d mag=%b want 1,0,0", motor_en, washer_count, magnet_on);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_lockout();
        test_full_clear();
        test_enable_mid_pickup();
        test_ignored_clear();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
